uart_transceiver: RTL

- Full-duplex 8N1 UART serving the memory-mapped peripheral block: the TX holding register and enable pulse from the bus side feed the transmitter, and the receiver feeds the RX data register and status flags read back over the bus.
- Drives the board pin PC_Uart_txd and samples PC_Uart_rxd.
- Single clock domain; shared 16x-oversampling baud tick generator.

---
 rtl/uart_transceiver.sv | 99 +++++++++
 1 files changed

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART with shared 16x baud tick, sticky status flags and break-tolerant receiver
module uart_transceiver #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_status,
  output logic       tx_flag,
  input  logic       tx_clear,
  output logic [7:0] rx_data,
  output logic       rx_flag,
  input  logic       rx_clear,
  output logic       rx_error,
  input  logic       rxd,
  output logic       txd
);
  localparam int CW = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [CW-1:0] cnt;
  logic          tick;
  state_t        tx_st, tx_nx, rx_st, rx_nx;
  logic [3:0]    tx_tc, rx_tc;
  logic [2:0]    tx_idx, rx_idx;
  logic [7:0]    tx_sh, rx_sh;
  logic          tx_end, rx_mid, rx_end, rs1, rs2, armed, stop_ok, stop_bad;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + CW'(1);
  assign tx_end    = tick && tx_tc == 4'd15;
  assign tx_status = tx_st != IDLE;
  assign txd       = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[tx_idx] : 1'b1;
  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      IDLE:    tx_nx = tx_start ? START : IDLE;
      START:   tx_nx = tx_end ? DATA : START;
      DATA:    tx_nx = tx_end && tx_idx == 3'd7 ? STOP : DATA;
      STOP:    tx_nx = tx_end ? IDLE : STOP;
      default: tx_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_st   <= IDLE;
      tx_tc   <= '0;
      tx_idx  <= '0;
      tx_sh   <= '0;
      tx_flag <= 1'b0;
    end else begin
      tx_st   <= tx_nx;
      tx_tc   <= tx_st != tx_nx ? 4'd0 : tick ? tx_tc + 4'd1 : tx_tc;
      tx_idx  <= tx_st == IDLE ? 3'd0 : tx_st == DATA && tx_end ? tx_idx + 3'd1 : tx_idx;
      tx_sh   <= tx_st == IDLE && tx_start ? tx_data : tx_sh;
      tx_flag <= (tx_st == STOP && tx_end) | (tx_flag & ~tx_clear);
    end
  assign rx_mid   = tick && rx_tc == 4'd7;
  assign rx_end   = tick && rx_tc == 4'd15;
  assign stop_ok  = rx_st == STOP && rx_end && rs2;
  assign stop_bad = rx_st == STOP && rx_end && !rs2;
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      IDLE:    rx_nx = tick && !rs2 && armed ? START : IDLE;
      START:   rx_nx = rx_mid ? (rs2 ? IDLE : DATA) : START;
      DATA:    rx_nx = rx_end && rx_idx == 3'd7 ? STOP : DATA;
      STOP:    rx_nx = rx_end ? IDLE : STOP;
      default: rx_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rs1      <= 1'b1;
      rs2      <= 1'b1;
      armed    <= 1'b1;
      rx_st    <= IDLE;
      rx_tc    <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_flag  <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rs1      <= rxd;
      rs2      <= rs1;
      armed    <= stop_bad ? 1'b0 : rs2 ? 1'b1 : armed;
      rx_st    <= rx_nx;
      rx_tc    <= rx_st != rx_nx ? 4'd0 : tick ? rx_tc + 4'd1 : rx_tc;
      rx_idx   <= rx_st == IDLE ? 3'd0 : rx_st == DATA && rx_end ? rx_idx + 3'd1 : rx_idx;
      rx_sh    <= rx_st == DATA && rx_end ? {rs2, rx_sh[7:1]} : rx_sh;
      rx_data  <= stop_ok ? rx_sh : rx_data;
      rx_flag  <= stop_ok | (rx_flag & ~rx_clear);
      rx_error <= stop_bad | (stop_ok & rx_flag) | (rx_error & ~rx_clear);
    end
endmodule
